// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package pc_fetch_unit_pkg;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_REQ  = 2'd1;
  localparam fetch_state_t ST_HOLD = 2'd2;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry skid buffer holding a fetched word and its PC while the IF/ID slot is stalled.
module fetch_skid_reg
  import pc_fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic         drain,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry,
  output logic         valid
);

  // Clear (redirect flush) beats a load arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      entry <= load_entry;
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack handshake, IF/ID output slot with skid.
// Optional macro PC_ALIGN_CHECK_EN: word-align redirect targets and flag misaligned ones.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic [31:0]  addr_q, addr_nx;
  logic [31:0]  redirect_target;
  logic         kill, kill_nx;
  logic         instr_valid_nx;
  fetch_entry_t out_q, out_nx;
  fetch_entry_t skid_entry;
  logic         skid_valid, skid_load, skid_clear, skid_drain;
  logic         slot_free;

`ifdef PC_ALIGN_CHECK_EN
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err <= 1'b0;
    else if (redirect && (redirect_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
  end
`else
  assign redirect_target = redirect_pc;
  assign misalign_err    = 1'b0;
`endif

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = addr_q;
  assign instr     = out_q.word;
  assign instr_pc  = out_q.pc;
  assign pc_plus4  = out_q.pc + PC_INCR;
  assign slot_free = !instr_valid || !stall;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    kill_nx        = kill;
    instr_valid_nx = instr_valid;
    out_nx         = out_q;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    skid_drain     = 1'b0;
    if (redirect) begin
      // A response still owed to the old stream must be swallowed when it arrives.
      instr_valid_nx = 1'b0;
      skid_clear     = 1'b1;
      pc_nx          = redirect_target;
      kill_nx        = imem_req && !imem_ack;
      state_nx       = ST_REQ;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_REQ;
        ST_REQ: begin
          if (imem_ack && kill) begin
            kill_nx = 1'b0;
          end else if (imem_ack) begin
            pc_nx = pc + PC_INCR;
            if (slot_free) begin
              out_nx         = '{word: imem_data, pc: addr_q};
              instr_valid_nx = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_nx  = ST_HOLD;
            end
          end else if (instr_valid && !stall) begin
            instr_valid_nx = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            out_nx         = skid_entry;
            instr_valid_nx = skid_valid;
            skid_drain     = 1'b1;
            state_nx       = ST_REQ;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
    // The address of an outstanding killed request must stay stable until its ack.
    addr_nx = kill_nx ? addr_q : pc_nx;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      addr_q      <= RESET_PC;
      kill        <= 1'b0;
      instr_valid <= 1'b0;
      out_q       <= '0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      addr_q      <= addr_nx;
      kill        <= kill_nx;
      instr_valid <= instr_valid_nx;
      out_q       <= out_nx;
    end
  end

  fetch_skid_reg u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .clear      (skid_clear),
    .drain      (skid_drain),
    .load_entry ('{word: imem_data, pc: addr_q}),
    .entry      (skid_entry),
    .valid      (skid_valid)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table, hand sequences and a consumed-instruction scoreboard.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  int wait_cnt = 0;
  bit mem_en = 1'b1;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc;
  } vec_t;
  vec_t vecs[11];

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .pc_plus4     (pc_plus4),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks a request after mem_lat waiting cycles; ack is decided mid-cycle.
  always @(negedge clk) begin
    if (imem_ack || !imem_req || !rst_n) wait_cnt = 0;
    imem_ack = 1'b0;
    if (imem_req && mem_en && rst_n) begin
      if (wait_cnt >= mem_lat) begin
        imem_ack  = 1'b1;
        imem_data = mem_word(imem_addr);
      end else begin
        wait_cnt++;
      end
    end
  end

  // Downstream consumer: an instruction leaves IF/ID at the next edge when valid and not stalled.
  always @(negedge clk) begin
    if (rst_n && instr_valid && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got instr_pc %h want no instruction", instr_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_pc", instr_pc, e);
        check("sb_word", instr, mem_word(e));
      end
    end
  end

  // Leaves the bench at the start of cycle 0 (reset just released, IDLE).
  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    mem_en = 1'b1;
    mem_lat = 0;
    exp_q.delete();
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
    vecs[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
    vecs[5]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h10};
    vecs[6]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
    vecs[7]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
    vecs[8]  = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h10};
    vecs[9]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h14};
    vecs[10] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h18};

    // Reset state and zero-wait streaming with a three-cycle stall.
    @(negedge clk);
    check("inrst_req", imem_req, 1'b0);
    check("inrst_valid", instr_valid, 1'b0);
    do_reset();
    @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_ipc", instr_pc, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_mis", misalign_err, 1'b0);
    for (int a = 0; a <= 32'h1C; a += 4) exp_q.push_back(32'(a));
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      stall = vecs[i].stall;
      @(negedge clk);
      check($sformatf("vec%0d_req", i), imem_req, vecs[i].req);
      check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("vec%0d_valid", i), instr_valid, vecs[i].valid);
      check($sformatf("vec%0d_ipc", i), instr_pc, vecs[i].ipc);
      if (vecs[i].valid) check($sformatf("vec%0d_instr", i), instr, mem_word(vecs[i].ipc));
    end
    next_cycle();
    mem_en = 1'b0;
    @(negedge clk);
    check("stream_last_ipc", instr_pc, 32'h1C);
    next_cycle();
    @(negedge clk);
    check("stream_bubble", instr_valid, 1'b0);
    check("stream_req_hold", imem_req, 1'b1);
    check("stream_addr_hold", imem_addr, 32'h20);
    check("stream_sb_empty", exp_q.size(), 32'h0);

    // Redirect while the request to 8 waits two cycles for its ack.
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h100);
    next_cycle();
    next_cycle();
    next_cycle();
    mem_lat = 2;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    check("kill_addr_pre", imem_addr, 32'h8);
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("kill_req_c4", imem_req, 1'b1);
    check("kill_addr_c4", imem_addr, 32'h8);
    check("kill_valid_c4", instr_valid, 1'b0);
    next_cycle();
    @(negedge clk);
    check("kill_addr_c5", imem_addr, 32'h8);
    check("kill_valid_c5", instr_valid, 1'b0);
    next_cycle();
    mem_lat = 0;
    @(negedge clk);
    check("kill_valid_c6", instr_valid, 1'b0);
    check("kill_new_req", imem_req, 1'b1);
    check("kill_new_addr", imem_addr, 32'h100);
    next_cycle();
    mem_en = 1'b0;
    @(negedge clk);
    check("kill_new_valid", instr_valid, 1'b1);
    check("kill_new_ipc", instr_pc, 32'h100);
    next_cycle();
    @(negedge clk);
    check("kill_sb_empty", exp_q.size(), 32'h0);

    // Redirect together with ack, then redirect out of HOLD while stalled.
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h300);
    next_cycle();
    next_cycle();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("same_valid", instr_valid, 1'b0);
    check("same_req", imem_req, 1'b1);
    check("same_addr", imem_addr, 32'h200);
    next_cycle();
    stall = 1'b1;
    @(negedge clk);
    check("same_ipc", instr_pc, 32'h200);
    check("same_addr_next", imem_addr, 32'h204);
    next_cycle();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    check("hold_req", imem_req, 1'b0);
    check("hold_ipc", instr_pc, 32'h200);
    check("hold_valid", instr_valid, 1'b1);
    next_cycle();
    redirect = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("hold_rd_valid", instr_valid, 1'b0);
    check("hold_rd_req", imem_req, 1'b1);
    check("hold_rd_addr", imem_addr, 32'h300);
    next_cycle();
    mem_en = 1'b0;
    @(negedge clk);
    check("hold_rd_ipc", instr_pc, 32'h300);
    next_cycle();
    @(negedge clk);
    check("hold_sb_empty", exp_q.size(), 32'h0);

    // PC wraps from FFFF_FFFC to 0.
    do_reset();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    next_cycle();
    next_cycle();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    check("wrap_addr_f8", imem_addr, 32'hFFFF_FFF8);
    next_cycle();
    @(negedge clk);
    check("wrap_addr_fc", imem_addr, 32'hFFFF_FFFC);
    next_cycle();
    mem_en = 1'b0;
    @(negedge clk);
    check("wrap_addr_0", imem_addr, 32'h0);
    check("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    next_cycle();
    @(negedge clk);
    check("wrap_sb_empty", exp_q.size(), 32'h0);

    // Misaligned redirect target, then reset clears the sticky flag mid-request.
    do_reset();
    exp_q.push_back(32'h0);
    next_cycle();
    next_cycle();
    redirect = 1'b1;
    redirect_pc = 32'h102;
    next_cycle();
    redirect = 1'b0;
    mem_en = 1'b0;
    @(negedge clk);
`ifdef PC_ALIGN_CHECK_EN
    check("mis_addr", imem_addr, 32'h100);
    check("mis_flag", misalign_err, 1'b1);
`else
    check("mis_addr", imem_addr, 32'h102);
    check("mis_flag", misalign_err, 1'b0);
`endif
    next_cycle();
    next_cycle();
    @(negedge clk);
`ifdef PC_ALIGN_CHECK_EN
    check("mis_sticky", misalign_err, 1'b1);
`else
    check("mis_sticky", misalign_err, 1'b0);
`endif
    check("mis_req_pending", imem_req, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_req", imem_req, 1'b0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_valid", instr_valid, 1'b0);
    check("midrst_pc4", pc_plus4, 32'h4);
    check("midrst_mis", misalign_err, 1'b0);
    check("mis_sb_empty", exp_q.size(), 32'h0);
    next_cycle();
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
